pe_mac_seq: RTL and testbench
=============================

// Module: pe_mac_seq
// PURPOSE
//  Per-tile sequencer for the PE MAC chain. Accepts one accumulation job (length, weight and map buffer bases).
//  Issues weight/map buffer reads, then drives the chain's data-valid strobes and its mac_en/mac_clear controls.
//  Waits for the chain to drain, then presents a result-valid handshake to the writeback stage.
//  Sits between the tile job dispatcher and the pe_mac chain plus its two operand buffers.
// PARAMETERS
//  ADDR_WIDTH  10  operand buffer address width
//  LEN_WIDTH   10  accumulation-step count width
//  PE_DEPTH    8   PEs in the chain (each adds 1 cycle of vld/data delay)
//  RD_LAT      1   operand buffer read latency in cycles, >=1
// PORTS
//  i_clk         in   1           clock
//  i_rst         in   1           synchronous active-high reset
//  i_start       in   1           job start pulse; sampled only in IDLE
//  i_len         in   LEN_WIDTH   accumulation steps for the job
//  i_waddr_base  in   ADDR_WIDTH  first weight-buffer address
//  i_maddr_base  in   ADDR_WIDTH  first map-buffer address
//  i_hold        in   1           operand buffers not ready; pauses issue
//  o_busy        out  1           job in progress (state != IDLE)
//  o_done        out  1           1-cycle pulse, job retired
//  o_wbuf_rd     out  1           weight-buffer read strobe
//  o_wbuf_addr   out  ADDR_WIDTH  weight-buffer read address
//  o_mbuf_rd     out  1           map-buffer read strobe
//  o_mbuf_addr   out  ADDR_WIDTH  map-buffer read address
//  o_wdata_vld   out  1           to chain i_wdata_vld (= o_wbuf_rd delayed RD_LAT)
//  o_mdata_vld   out  1           to chain i_mdata_vld (= o_mbuf_rd delayed RD_LAT)
//  o_mac_en      out  1           to chain i_mac_en
//  o_mac_clear   out  1           to chain i_mac_clear
//  o_res_vld     out  1           chain accumulators final, o_mac_result stable
//  i_res_rdy     in   1           writeback accepts result
//  o_hold_cyc    out  32          perf: ISSUE cycles stalled by i_hold
//  o_job_cyc     out  32          perf: cycles from start accept to done
// BEHAVIOUR
//  - Reset: state=IDLE, step/drain counters=0, vld delay pipe flushed. Every output is 0.
//  - FSM IDLE->CLEAR->ISSUE->DRAIN->OUT->IDLE. All outputs are registered.
//  - IDLE: on i_start with i_len!=0, latch len and bases, then go to CLEAR.
//    If i_len==0: o_done pulses the next cycle, no reads are issued, and the FSM stays in IDLE.
//  - CLEAR: exactly 1 cycle; o_mac_clear=1, o_mac_en=1.
//  - ISSUE: on each cycle with !i_hold, o_wbuf_rd=o_mbuf_rd=1.
//    Addresses are base+cnt mod 2^ADDR_WIDTH (wraps silently); cnt increments.
//    With i_hold=1, strobes are 0 and cnt holds. After len reads, go to DRAIN.
//  - DRAIN: a fixed RD_LAT+PE_DEPTH+1 cycles, independent of i_hold.
//  - OUT: o_res_vld=1 until i_res_rdy. The handshake cycle returns to IDLE.
//    o_done=1 and o_busy=0 in the following cycle.
//  - o_mac_en=1 in CLEAR/ISSUE/DRAIN/OUT and 0 in IDLE; dropping it zeroes the chain accumulators.
//  - The vld delay pipe keeps shifting in every state, so in-flight reads always reach the chain before OUT.
//  - i_start while busy is ignored, with no queuing.
//  - i_rst mid-job: abort the next cycle, go to IDLE with all outputs 0, and emit no o_done.
// CONFIGURATION
//  - PE_MAC_SEQ_PERF_EN defined:
//    - o_hold_cyc and o_job_cyc both clear to 0 on an accepted i_start.
//    - Both count as described under PORTS, saturate at 2^32-1, and hold their value after o_done.
//  - Undefined: no counter logic is built; o_hold_cyc=o_job_cyc=0 and the ports remain present.
// TESTING
//  - len=4, bases 0x10/0x20, hold=0, rdy=1:
//    - reads at addrs 0x10..0x13 and 0x20..0x23 on 4 consecutive cycles;
//    - vld strobes lag the reads by RD_LAT;
//    - o_res_vld rises RD_LAT+PE_DEPTH+1 cycles after the last read;
//    - o_done pulses once.
//  - len=3 with i_hold=1 on issue cycle 2 -> 3 reads total, a 1-cycle gap in o_wbuf_rd, o_hold_cyc=1 with PERF_EN.
//  - Base 0x3FE, len=4 (ADDR_WIDTH=10) -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
//  - i_len=0 -> o_done 1 cycle later; o_busy, o_mac_en, o_wbuf_rd and o_mbuf_rd all stay 0.
//  - i_res_rdy low for 5 cycles in OUT -> o_res_vld held 5 cycles; o_mac_en stays 1; done 1 cycle after rdy.
//  - i_rst in ISSUE at step 2 of 8 -> next cycle all outputs 0; a new i_start=len 2 then runs normally.

Source files
------------

// File: rtl/pe_mac_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : pe_mac_seq_if
// Purpose  : Job, operand-buffer, chain-control and writeback signals of the
//            PE MAC tile sequencer, bundled with dispatcher/sequencer views.
// Revision : 1.0  initial release
// ============================================================================
interface pe_mac_seq_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 10
);
   // Job request from the dispatcher
   logic                  i_start;
   logic [LEN_WIDTH-1:0]  i_len;
   logic [ADDR_WIDTH-1:0] i_waddr_base;
   logic [ADDR_WIDTH-1:0] i_maddr_base;
   logic                  i_hold;
   logic                  i_res_rdy;

   // Status, buffer reads, chain controls and perf counters
   logic                  o_busy;
   logic                  o_done;
   logic                  o_wbuf_rd;
   logic [ADDR_WIDTH-1:0] o_wbuf_addr;
   logic                  o_mbuf_rd;
   logic [ADDR_WIDTH-1:0] o_mbuf_addr;
   logic                  o_wdata_vld;
   logic                  o_mdata_vld;
   logic                  o_mac_en;
   logic                  o_mac_clear;
   logic                  o_res_vld;
   logic [31:0]           o_hold_cyc;
   logic [31:0]           o_job_cyc;

   // Dispatcher / writeback side
   modport master (
      output i_start, i_len, i_waddr_base, i_maddr_base, i_hold, i_res_rdy,
      input  o_busy, o_done, o_wbuf_rd, o_wbuf_addr, o_mbuf_rd, o_mbuf_addr,
             o_wdata_vld, o_mdata_vld, o_mac_en, o_mac_clear, o_res_vld,
             o_hold_cyc, o_job_cyc
   );

   // Sequencer side
   modport slave (
      input  i_start, i_len, i_waddr_base, i_maddr_base, i_hold, i_res_rdy,
      output o_busy, o_done, o_wbuf_rd, o_wbuf_addr, o_mbuf_rd, o_mbuf_addr,
             o_wdata_vld, o_mdata_vld, o_mac_en, o_mac_clear, o_res_vld,
             o_hold_cyc, o_job_cyc
   );
endinterface
`default_nettype wire

// File: rtl/pe_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : pe_mac_seq
// Purpose  : Per-tile sequencer for the PE MAC chain. Accepts one job, clears
//            the chain, issues weight/map buffer reads, drains the chain and
//            hands the result to writeback.
// Options  : PE_MAC_SEQ_PERF_EN - builds the hold/job cycle counters;
//            without it o_hold_cyc/o_job_cyc are tied to 0.
// Revision : 1.0  initial release
// ============================================================================
module pe_mac_seq #(
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 10,
   parameter int PE_DEPTH   = 8,
   parameter int RD_LAT     = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   pe_mac_seq_if.slave bus
);

   // Cycles the chain needs after the last read before every accumulator is final
   localparam int DRAIN_CYC = RD_LAT + PE_DEPTH + 1;
   localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_ISSUE = 3'd2,
      S_DRAIN = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t                r_state;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_cnt;
   logic [ADDR_WIDTH-1:0] r_wbase;
   logic [ADDR_WIDTH-1:0] r_mbase;
   logic [DRAIN_W-1:0]    r_drain;

   logic                  r_busy;
   logic                  r_done;
   logic                  r_wbuf_rd;
   logic                  r_mbuf_rd;
   logic [ADDR_WIDTH-1:0] r_wbuf_addr;
   logic [ADDR_WIDTH-1:0] r_mbuf_addr;
   logic                  r_mac_en;
   logic                  r_mac_clear;
   logic                  r_res_vld;

   logic [RD_LAT-1:0]     r_wvld_pipe;
   logic [RD_LAT-1:0]     r_mvld_pipe;

   logic [LEN_WIDTH-1:0]  w_cnt_nxt;

   assign w_cnt_nxt = r_cnt + LEN_WIDTH'(1);

   // Job sequencing FSM; every output it drives is a register updated here
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_cnt       <= '0;
         r_wbase     <= '0;
         r_mbase     <= '0;
         r_drain     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_wbuf_rd   <= 1'b0;
         r_mbuf_rd   <= 1'b0;
         r_wbuf_addr <= '0;
         r_mbuf_addr <= '0;
         r_mac_en    <= 1'b0;
         r_mac_clear <= 1'b0;
         r_res_vld   <= 1'b0;
      end else begin
         // Pulse-type outputs default low every cycle
         r_done      <= 1'b0;
         r_wbuf_rd   <= 1'b0;
         r_mbuf_rd   <= 1'b0;
         r_mac_clear <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  if (bus.i_len == '0) begin
                     // Empty job retires immediately without touching the chain
                     r_done <= 1'b1;
                  end else begin
                     r_len       <= bus.i_len;
                     r_wbase     <= bus.i_waddr_base;
                     r_mbase     <= bus.i_maddr_base;
                     r_cnt       <= '0;
                     r_state     <= S_CLEAR;
                     r_busy      <= 1'b1;
                     r_mac_en    <= 1'b1;
                     r_mac_clear <= 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               r_state <= S_ISSUE;
            end
            S_ISSUE: begin
               if (!bus.i_hold) begin
                  r_wbuf_rd   <= 1'b1;
                  r_mbuf_rd   <= 1'b1;
                  r_wbuf_addr <= r_wbase + ADDR_WIDTH'(r_cnt);
                  r_mbuf_addr <= r_mbase + ADDR_WIDTH'(r_cnt);
                  r_cnt       <= w_cnt_nxt;
                  if (w_cnt_nxt == r_len) begin
                     r_state <= S_DRAIN;
                     r_drain <= '0;
                  end
               end
            end
            S_DRAIN: begin
               if (r_drain == DRAIN_W'(DRAIN_CYC - 1)) begin
                  r_state   <= S_OUT;
                  r_res_vld <= 1'b1;
               end else begin
                  r_drain <= r_drain + DRAIN_W'(1);
               end
            end
            S_OUT: begin
               if (bus.i_res_rdy) begin
                  r_state   <= S_IDLE;
                  r_res_vld <= 1'b0;
                  r_busy    <= 1'b0;
                  r_mac_en  <= 1'b0;
                  r_done    <= 1'b1;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_busy    <= 1'b0;
               r_mac_en  <= 1'b0;
               r_res_vld <= 1'b0;
            end
         endcase
      end
   end

   // Data-valid strobes follow the read strobes by the buffer read latency
   generate
      if (RD_LAT == 1) begin : g_vld_lat1
         // Single-stage delay
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_wvld_pipe <= '0;
               r_mvld_pipe <= '0;
            end else begin
               r_wvld_pipe <= r_wbuf_rd;
               r_mvld_pipe <= r_mbuf_rd;
            end
         end
      end else begin : g_vld_latn
         // Multi-stage shift; keeps shifting in every state so no read is lost
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_wvld_pipe <= '0;
               r_mvld_pipe <= '0;
            end else begin
               r_wvld_pipe <= {r_wvld_pipe[RD_LAT-2:0], r_wbuf_rd};
               r_mvld_pipe <= {r_mvld_pipe[RD_LAT-2:0], r_mbuf_rd};
            end
         end
      end
   endgenerate

`ifdef PE_MAC_SEQ_PERF_EN
   logic [31:0] r_hold_cyc;
   logic [31:0] r_job_cyc;

   // Perf counters: cleared on start, job_cyc counts busy cycles, hold_cyc counts stalled issue cycles
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hold_cyc <= '0;
         r_job_cyc  <= '0;
      end else if (r_state == S_IDLE) begin
         if (bus.i_start) begin
            r_hold_cyc <= '0;
            r_job_cyc  <= '0;
         end
      end else begin
         if (r_job_cyc != '1) begin
            r_job_cyc <= r_job_cyc + 32'd1;
         end
         if ((r_state == S_ISSUE) && bus.i_hold && (r_hold_cyc != '1)) begin
            r_hold_cyc <= r_hold_cyc + 32'd1;
         end
      end
   end

   assign bus.o_hold_cyc = r_hold_cyc;
   assign bus.o_job_cyc  = r_job_cyc;
`else
   assign bus.o_hold_cyc = '0;
   assign bus.o_job_cyc  = '0;
`endif

   assign bus.o_busy      = r_busy;
   assign bus.o_done      = r_done;
   assign bus.o_wbuf_rd   = r_wbuf_rd;
   assign bus.o_wbuf_addr = r_wbuf_addr;
   assign bus.o_mbuf_rd   = r_mbuf_rd;
   assign bus.o_mbuf_addr = r_mbuf_addr;
   assign bus.o_wdata_vld = r_wvld_pipe[RD_LAT-1];
   assign bus.o_mdata_vld = r_mvld_pipe[RD_LAT-1];
   assign bus.o_mac_en    = r_mac_en;
   assign bus.o_mac_clear = r_mac_clear;
   assign bus.o_res_vld   = r_res_vld;

endmodule
`default_nettype wire

// File: tb/tb_pe_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_mac_seq
// Purpose  : Scoreboard bench for pe_mac_seq. The driver pushes the expected
//            reads, clear strobe and retirement record of each job; a negedge
//            monitor pops and compares whenever the sequencer presents them.
// Options  : PE_MAC_SEQ_PERF_EN selects counter expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_pe_mac_seq;
   localparam int AW        = 10;
   localparam int LW        = 10;
   localparam int PE_DEPTH  = 8;
   localparam int RD_LAT    = 2;
   localparam int DRAIN_CYC = RD_LAT + PE_DEPTH + 1;
`ifdef PE_MAC_SEQ_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct {
      logic [AW-1:0] w;
      logic [AW-1:0] m;
   } addr_t;

   typedef struct {
      int done_at;   // -1: one cycle after the result handshake
      int hold_cyc;
      int job_cyc;
   } done_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;

   addr_t addr_q[$];
   int    vld_q[$];
   int    clr_q[$];
   done_t done_q[$];

   int   last_rd_cyc = -1;
   int   hs_done_cyc = -1;
   logic prev_res_vld = 1'b0;

   pe_mac_seq_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

   pe_mac_seq #(
      .ADDR_WIDTH (AW),
      .LEN_WIDTH  (LW),
      .PE_DEPTH   (PE_DEPTH),
      .RD_LAT     (RD_LAT)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"},
            {36'd0, bus.o_busy, bus.o_done, bus.o_wbuf_rd, bus.o_wbuf_addr, bus.o_mbuf_rd,
             bus.o_mbuf_addr, bus.o_wdata_vld, bus.o_mdata_vld, bus.o_mac_en,
             bus.o_mac_clear, bus.o_res_vld}, 64'd0);
      check({tag, "_perf"}, {bus.o_hold_cyc, bus.o_job_cyc}, 64'd0);
   endtask

   // Monitor: compares presented events against the scoreboard queues
   always @(negedge clk) begin
      if (mon_en) begin
         logic  exp_v;
         logic  exp_c;
         addr_t a;
         done_t d;

         check("mac_en_vs_busy", bus.o_mac_en, bus.o_busy);

         if (bus.o_wbuf_rd || bus.o_mbuf_rd)
            check("mbuf_rd_vs_wbuf_rd", bus.o_mbuf_rd, bus.o_wbuf_rd);
         if (bus.o_wbuf_rd) begin
            if (addr_q.size() == 0) begin
               check("unexpected_read", bus.o_wbuf_rd, 1'b0);
            end else begin
               a = addr_q.pop_front();
               check("wbuf_addr", bus.o_wbuf_addr, a.w);
               check("mbuf_addr", bus.o_mbuf_addr, a.m);
            end
            last_rd_cyc = cyc;
            vld_q.push_back(cyc + RD_LAT);
         end

         while (vld_q.size() > 0 && vld_q[0] < cyc) begin
            check("missed_wdata_vld", 1'b0 + bus.o_wdata_vld, 1'b1);
            void'(vld_q.pop_front());
         end
         exp_v = (vld_q.size() > 0 && vld_q[0] == cyc);
         if (exp_v || bus.o_wdata_vld) begin
            check("wdata_vld", bus.o_wdata_vld, exp_v);
            if (exp_v) void'(vld_q.pop_front());
         end
         if (bus.o_wdata_vld || bus.o_mdata_vld)
            check("mdata_vld_vs_wdata_vld", bus.o_mdata_vld, bus.o_wdata_vld);

         exp_c = (clr_q.size() > 0 && clr_q[0] == cyc);
         if (exp_c || bus.o_mac_clear) begin
            check("mac_clear", bus.o_mac_clear, exp_c);
            check("mac_en_with_clear", bus.o_mac_en, 1'b1);
            if (exp_c) void'(clr_q.pop_front());
         end

         if (bus.o_res_vld && !prev_res_vld)
            check("res_vld_latency", cyc, last_rd_cyc + DRAIN_CYC);
         prev_res_vld = bus.o_res_vld;
         if (bus.o_res_vld && bus.i_res_rdy)
            hs_done_cyc = cyc + 1;

         if (bus.o_done) begin
            if (done_q.size() == 0) begin
               check("unexpected_done", bus.o_done, 1'b0);
            end else begin
               d = done_q.pop_front();
               check("done_cycle", cyc, (d.done_at >= 0) ? d.done_at : hs_done_cyc);
               check("hold_cyc_at_done", bus.o_hold_cyc, d.hold_cyc);
               check("job_cyc_at_done", bus.o_job_cyc, d.job_cyc);
               check("busy_at_done", bus.o_busy, 1'b0);
               check("res_vld_at_done", bus.o_res_vld, 1'b0);
            end
         end
      end
   end

   // One job: queue its expected behaviour, then drive it through to retirement
   task automatic run_job(input int len, input logic [AW-1:0] wb, input logic [AW-1:0] mb,
                          input logic [31:0] hmask, input int rdy_wait, input bit do_rst);
      int    s;
      int    reads;
      int    holds;
      int    j;
      int    seen;
      done_t d;
      addr_t a;

      bus.i_start      = 1'b1;
      bus.i_len        = LW'(len);
      bus.i_waddr_base = wb;
      bus.i_maddr_base = mb;
      bus.i_hold       = 1'b0;
      bus.i_res_rdy    = 1'b0;
      s = cyc + 1;                       // edge that samples this start

      if (len == 0) begin
         d.done_at = s; d.hold_cyc = 0; d.job_cyc = 0;
         done_q.push_back(d);
         tick();
         bus.i_start = 1'b0;
         tick();
         tick();
         return;
      end

      for (int i = 0; i < len; i++) begin
         a.w = wb + AW'(i);
         a.m = mb + AW'(i);
         addr_q.push_back(a);
      end
      clr_q.push_back(s);

      tick();
      // Inputs seen during the clear cycle: all must be ignored
      bus.i_start      = 1'($urandom_range(0, 1));
      bus.i_len        = LW'($urandom_range(1, 1023));
      bus.i_waddr_base = AW'($urandom);
      bus.i_maddr_base = AW'($urandom);
      bus.i_hold       = 1'($urandom_range(0, 1));
      tick();

      reads = 0; holds = 0; j = 0;
      while (reads < len) begin
         if (do_rst && reads == 2) begin
            rst         = 1'b1;
            bus.i_start = 1'b0;
            bus.i_hold  = 1'b0;
            tick();
            check_all_zero("abort");
            addr_q.delete();
            vld_q.delete();
            clr_q.delete();
            rst = 1'b0;
            tick();
            return;
         end
         bus.i_hold       = (j < 32) ? hmask[j] : 1'b0;
         bus.i_start      = 1'($urandom_range(0, 1));
         bus.i_len        = LW'($urandom_range(1, 1023));
         bus.i_waddr_base = AW'($urandom);
         tick();
         if (bus.i_hold) holds++;
         else reads++;
         j++;
      end

      d.done_at  = -1;
      d.hold_cyc = PERF ? holds : 0;
      d.job_cyc  = PERF ? (1 + len + holds + DRAIN_CYC + rdy_wait + 1) : 0;
      done_q.push_back(d);

      for (int k = 0; k < DRAIN_CYC; k++) begin
         bus.i_hold  = 1'($urandom_range(0, 1));
         bus.i_start = 1'($urandom_range(0, 1));
         tick();
      end
      bus.i_start = 1'b0;
      bus.i_hold  = 1'b0;

      seen = 0;
      while (!bus.o_res_vld && seen < 50) begin
         tick();
         seen++;
      end
      check("res_vld_after_drain", bus.o_res_vld, 1'b1);
      if (!bus.o_res_vld) return;

      for (int w = 0; w < rdy_wait; w++) begin
         tick();
         check("res_vld_held", bus.o_res_vld, 1'b1);
         check("mac_en_in_out", bus.o_mac_en, 1'b1);
      end
      bus.i_res_rdy = 1'b1;
      tick();
      bus.i_res_rdy = 1'b0;
      check("res_vld_after_rdy", bus.o_res_vld, 1'b0);
      check("mac_en_after_rdy", bus.o_mac_en, 1'b0);
      tick();
   endtask

   // Stimulus: reset, directed jobs, then randomized jobs
   initial begin
      bus.i_start      = 1'b0;
      bus.i_len        = '0;
      bus.i_waddr_base = '0;
      bus.i_maddr_base = '0;
      bus.i_hold       = 1'b0;
      bus.i_res_rdy    = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      rst    = 1'b0;
      mon_en = 1'b1;
      tick();

      run_job(4, 10'h010, 10'h020, 32'h0, 0, 1'b0);
      run_job(3, 10'h040, 10'h080, 32'b010, 0, 1'b0);
      run_job(4, 10'h3FE, 10'h3FF, 32'h0, 1, 1'b0);
      run_job(0, 10'h055, 10'h066, 32'h0, 0, 1'b0);
      run_job(5, 10'h100, 10'h200, 32'h0, 5, 1'b0);
      run_job(8, 10'h000, 10'h008, 32'h0, 0, 1'b1);
      run_job(2, 10'h030, 10'h031, 32'h0, 0, 1'b0);
      repeat (25) begin
         run_job($urandom_range(0, 20), AW'($urandom), AW'($urandom),
                 $urandom & $urandom & $urandom, $urandom_range(0, 4), 1'b0);
      end
      repeat (5) tick();

      check("reads_outstanding", addr_q.size(), 0);
      check("vld_outstanding", vld_q.size(), 0);
      check("clear_outstanding", clr_q.size(), 0);
      check("done_outstanding", done_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Hard time bound so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
